// File: rtl/alu_op_decoder_if.sv
// alu_op_decoder_if: instruction-issue channel and decoded-op channel, both valid/ready.
interface alu_op_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_sel;
    logic [4:0]  op_rs;
    logic [4:0]  op_rt;
    logic [4:0]  op_rd;
    logic        op_use_imm;
    logic [31:0] op_imm;
    logic        op_illegal;
    modport slave (
        input  in_valid, instr, op_ready,
        output in_ready, op_valid, op_sel, op_rs, op_rt, op_rd, op_use_imm, op_imm, op_illegal
    );
    modport master (
        output in_valid, instr, op_ready,
        input  in_ready, op_valid, op_sel, op_rs, op_rt, op_rd, op_use_imm, op_imm, op_illegal
    );
endinterface

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: MIPS word -> ALU select/operands, buffered in a DEPTH-entry FIFO.
// Optional ALU_DEC_STATS_EN adds a saturating illegal-entry counter o_ill_count.
module alu_op_decoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_op_decoder_if.slave  bus,
`ifdef ALU_DEC_STATS_EN
    output logic [CNT_W-1:0] o_ill_count,
`endif
    output logic [CNT_W-1:0] o_dec_count
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]  sel;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        use_imm;
        logic [31:0] imm;
        logic        illegal;
    } entry_t;

    entry_t           w_dec;
    entry_t           w_head;
    entry_t           r_mem [DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic [CNT_W-1:0] r_dec_cnt;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [5:0]       w_opc;
    logic [5:0]       w_fn;
    logic [31:0]      w_sext;
    logic [31:0]      w_zext;

    assign w_opc  = bus.instr[31:26];
    assign w_fn   = bus.instr[5:0];
    assign w_sext = {{16{bus.instr[15]}}, bus.instr[15:0]};
    assign w_zext = {16'h0, bus.instr[15:0]};

    always_comb begin
        w_dec         = '0;
        w_dec.rs      = bus.instr[25:21];
        w_dec.rt      = bus.instr[20:16];
        w_dec.rd      = (w_opc == 6'h00) ? bus.instr[15:11] : bus.instr[20:16];
        case (w_opc)
            6'h00: begin
                case (w_fn)
                    6'h24:   w_dec.sel = 4'd0;
                    6'h25:   w_dec.sel = 4'd1;
                    6'h20:   w_dec.sel = 4'd2;
                    6'h22:   w_dec.sel = 4'd6;
                    6'h2A:   w_dec.sel = 4'd7;
                    6'h27:   w_dec.sel = 4'd12;
                    default: w_dec.illegal = 1'b1;
                endcase
            end
            6'h08: begin w_dec.sel = 4'd2; w_dec.use_imm = 1'b1; w_dec.imm = w_sext; end
            6'h0C: begin w_dec.sel = 4'd0; w_dec.use_imm = 1'b1; w_dec.imm = w_zext; end
            6'h0D: begin w_dec.sel = 4'd1; w_dec.use_imm = 1'b1; w_dec.imm = w_zext; end
            6'h0A: begin w_dec.sel = 4'd7; w_dec.use_imm = 1'b1; w_dec.imm = w_sext; end
            6'h04: begin w_dec.sel = 4'd6; w_dec.imm = w_sext; end
            default: w_dec.illegal = 1'b1;
        endcase
    end

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    // NOP words complete the handshake but never occupy an entry
    assign w_push  = bus.in_valid && !w_full && (bus.instr != 32'h0);
    assign w_pop   = !w_empty && bus.op_ready;
    assign w_head  = w_empty ? '0 : r_mem[r_rp[AW-1:0]];

    assign bus.in_ready   = !w_full;
    assign bus.op_valid   = !w_empty;
    assign bus.op_sel     = w_head.sel;
    assign bus.op_rs      = w_head.rs;
    assign bus.op_rt      = w_head.rt;
    assign bus.op_rd      = w_head.rd;
    assign bus.op_use_imm = w_head.use_imm;
    assign bus.op_imm     = w_head.imm;
    assign bus.op_illegal = w_head.illegal;
    assign o_dec_count    = r_dec_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_dec_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp      <= r_wp + 1'b1;
                r_dec_cnt <= r_dec_cnt + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= w_dec;
    end

`ifdef ALU_DEC_STATS_EN
    logic [CNT_W-1:0] r_ill_cnt;

    assign o_ill_count = r_ill_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ill_cnt <= '0;
        else if (w_push && w_dec.illegal && !(&r_ill_cnt)) r_ill_cnt <= r_ill_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_alu_op_decoder.sv
// tb_alu_op_decoder: randomized + directed scoreboard bench for alu_op_decoder.
module tb_alu_op_decoder;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  sel;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        use_imm;
        logic [31:0] imm;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] dec_count;
`ifdef ALU_DEC_STATS_EN
    logic [15:0] ill_count;
`endif

    alu_op_decoder_if bus ();

    alu_op_decoder #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
`ifdef ALU_DEC_STATS_EN
        .o_ill_count (ill_count),
`endif
        .o_dec_count (dec_count)
    );

    always #5 clk = ~clk;

    exp_t exp_q [$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   m_dec   = 0;
    int   m_ill   = 0;
    bit   rnd     = 0;
    int   r_tab [int];
    int   i_tab [int];
    logic [5:0] fl [6] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27};
    logic [5:0] il [5] = '{6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h04};

    function automatic void check(string nm, logic [63:0] act, logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, req);
    endfunction

    function automatic exp_t ref_dec(logic [31:0] w);
        exp_t e = '0;
        int opc = int'(w[31:26]);
        int fn  = int'(w[5:0]);
        int v   = $signed(w[15:0]);
        e.rs = w[25:21];
        e.rt = w[20:16];
        e.rd = (opc == 0) ? w[15:11] : w[20:16];
        if (opc == 0 && r_tab.exists(fn)) e.sel = 4'(r_tab[fn]);
        else if (opc != 0 && i_tab.exists(opc)) begin
            e.sel     = 4'(i_tab[opc]);
            e.use_imm = (opc != 4);
            e.imm     = (opc == 12 || opc == 13) ? {16'h0, w[15:0]} : v;
        end else e.illegal = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] gen();
        int k = $urandom_range(0, 9);
        logic [31:0] w = $urandom;
        if (k < 5) w = {6'h00, w[25:6], fl[$urandom_range(0, 5)]};
        else if (k < 8) w = {il[$urandom_range(0, 4)], w[25:0]};
        else if (k == 9) w = 32'h0;
        return w;
    endfunction

    function automatic void model_push(logic [31:0] w);
        exp_t e;
        if (w == 32'h0) return;
        e = ref_dec(w);
        exp_q.push_back(e);
        m_dec++;
        if (e.illegal && m_ill < 65535) m_ill++;
    endfunction

    task automatic cycles(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd) bus.op_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send(logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.instr    = w;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                model_push(w);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (rnd) bus.op_ready = ($urandom_range(0, 3) != 0);
        end
        n_total++;
        $display("FAIL send_timeout: got in_ready=0 for 100 cycles want 1");
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.op_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            cycles(1);
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("drain_op_valid", 64'(bus.op_valid), 64'd0);
    endtask

    task automatic check_idle(string nm);
        check({nm, "_op_valid"}, 64'(bus.op_valid), 64'd0);
        check({nm, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({nm, "_dec_count"}, 64'(dec_count), 64'd0);
        check({nm, "_fields"}, 64'({bus.op_sel, bus.op_rs, bus.op_rt, bus.op_rd,
                                    bus.op_use_imm, bus.op_imm, bus.op_illegal}), 64'd0);
    endtask

    // monitor: pops the scoreboard on every output transfer, checks head stability
    initial begin
        exp_t e, act, held;
        bit   hold = 0;
        forever begin
            @(negedge clk);
            act = {bus.op_sel, bus.op_rs, bus.op_rt, bus.op_rd, bus.op_use_imm, bus.op_imm, bus.op_illegal};
            if (!rst_n) hold = 0;
            else begin
                if (hold && bus.op_valid) check("head_stable", 64'(act), 64'(held));
                hold = bus.op_valid && !bus.op_ready;
                held = act;
                if (bus.op_valid && bus.op_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_op: got %h want nothing", act);
                    end else begin
                        e = exp_q.pop_front();
                        check("op_entry", 64'(act), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        r_tab[6'h24] = 0; r_tab[6'h25] = 1; r_tab[6'h20] = 2;
        r_tab[6'h22] = 6; r_tab[6'h2A] = 7; r_tab[6'h27] = 12;
        i_tab[6'h08] = 2; i_tab[6'h0C] = 0; i_tab[6'h0D] = 1;
        i_tab[6'h0A] = 7; i_tab[6'h04] = 6;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.instr    = 32'h0;
        bus.op_ready = 1'b0;
        cycles(3);
        check_idle("rst");
        rst_n = 1'b1;
        cycles(1);
        // R-type
        bus.op_ready = 1'b1;
        send(32'h00851020);
        check("add_latency", 64'(bus.op_valid), 64'd1);
        check("add_fields", 64'({bus.op_sel, bus.op_rs, bus.op_rt, bus.op_rd, bus.op_use_imm}),
              64'({4'd2, 5'd4, 5'd5, 5'd2, 1'b0}));
        send(32'h00851027);
        check("nor_sel", 64'(bus.op_sel), 64'd12);
        // I-type
        send(32'h2082FFFF);
        check("addi_fields", 64'({bus.op_sel, bus.op_rd, bus.op_use_imm, bus.op_imm}),
              64'({4'd2, 5'd2, 1'b1, 32'hFFFFFFFF}));
        send(32'h3482FFFF);
        check("ori_fields", 64'({bus.op_sel, bus.op_imm}), 64'({4'd1, 32'h0000FFFF}));
        drain();
        check("dec_count_4", 64'(dec_count), 64'd4);
        // illegal and NOP
        send(32'hFC000000);
        check("illegal_flag", 64'({bus.op_illegal, bus.op_sel}), 64'({1'b1, 4'd0}));
        send(32'h00000000);
        check("nop_not_enqueued", 64'(bus.op_valid), 64'd0);
        check("nop_count", 64'(dec_count), 64'd5);
`ifdef ALU_DEC_STATS_EN
        check("ill_count_1", 64'(ill_count), 64'd1);
`endif
        drain();
        // reset mid-stream with entries pending
        bus.op_ready = 1'b0;
        send(32'h00851020);
        send(32'h2082FFFF);
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        exp_q.delete();
        m_dec = 0;
        m_ill = 0;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        // backpressure to full, then pop while full
        for (int i = 0; i < DEPTH; i++) begin
            w = gen();
            while (w == 32'h0) w = gen();
            send(w);
        end
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        w = 32'h00A53022;
        bus.in_valid = 1'b1;
        bus.instr    = w;
        cycles(3);
        check("held_count", 64'(dec_count), 64'(DEPTH));
        bus.op_ready = 1'b1;
        @(negedge clk);
        check("full_pop_no_push", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("after_pop_ready", 64'(bus.in_ready), 64'd1);
        model_push(w);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();
        check("bp_count", 64'(dec_count), 64'(DEPTH + 1));
        // randomized traffic
        rnd = 1;
        for (int i = 0; i < 300; i++) begin
            send(gen());
            if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
        end
        rnd = 0;
        drain();
        check("rand_dec_count", 64'(dec_count), 64'(m_dec & 16'hFFFF));
`ifdef ALU_DEC_STATS_EN
        check("rand_ill_count", 64'(ill_count), 64'(m_ill));
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
